// File: rtl/order_pkg.sv
// Shared types and helpers for the order_total datapath: FSM encoding,
// saturating add and the item-counter width.
package order_pkg;

  localparam int unsigned PRICE_W_DEF   = 4;
  localparam int unsigned NUM_W_DEF     = 4;
  localparam int unsigned TOTAL_W_DEF   = 10;
  localparam int unsigned MAX_ITEMS_DEF = 8;
  localparam int unsigned SAT_W         = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    ACC  = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef struct packed {
    logic             ovf;
    logic [SAT_W-1:0] sum;
  } sat_res_t;

  // Width of a counter that must hold 0..max_items inclusive.
  function automatic int unsigned item_cnt_w(input int unsigned max_items);
    return $clog2(max_items + 1);
  endfunction

  // Unsigned add clamped to 2^w-1; ovf flags that clamping happened.
  function automatic sat_res_t sat_add(input logic [SAT_W-1:0] a,
                                       input logic [SAT_W-1:0] b,
                                       input int unsigned      w);
    logic [SAT_W:0] s;
    logic [SAT_W:0] lim;
    sat_res_t       r;
    s     = {1'b0, a} + {1'b0, b};
    lim   = ((SAT_W+1)'(1) << w) - (SAT_W+1)'(1);
    r.ovf = (s > lim);
    r.sum = r.ovf ? lim[SAT_W-1:0] : s[SAT_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/seq_mult.sv
// Shift-add multiplier: one multiplier bit per cycle, bit 0 folded into the
// start edge so done is visible exactly NUM_W cycles after start.
module seq_mult #(
  parameter int unsigned PRICE_W = 4,
  parameter int unsigned NUM_W   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       start,
  input  logic [PRICE_W-1:0]         price,
  input  logic [NUM_W-1:0]           num,
  output logic                       busy,
  output logic                       done,
  output logic [PRICE_W+NUM_W-1:0]   product
);

  localparam int unsigned PROD_W = PRICE_W + NUM_W;
  localparam int unsigned CNT_W  = $clog2(NUM_W + 1);

  logic [PROD_W-1:0] r_mcand;
  logic [NUM_W-1:0]  r_mplier;
  logic [CNT_W-1:0]  r_cnt;
  logic [PROD_W-1:0] w_addend;
  logic [PROD_W-1:0] w_first;

  always_comb begin
    w_addend = r_mplier[0] ? r_mcand : '0;
    w_first  = num[0] ? PROD_W'(price) : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      product  <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        product  <= w_first;
        r_mcand  <= PROD_W'(price) << 1;
        r_mplier <= num >> 1;
        r_cnt    <= CNT_W'(NUM_W - 1);
        busy     <= (NUM_W > 1);
        done     <= (NUM_W == 1);
      end else if (busy) begin
        product  <= product + w_addend;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/order_total.sv
// Item-stream order accumulator: multiplies each (price, num) item, adds the
// line price into a saturating total and hands the total off on completion.
module order_total
  import order_pkg::*;
#(
  parameter int unsigned PRICE_W   = PRICE_W_DEF,
  parameter int unsigned NUM_W     = NUM_W_DEF,
  parameter int unsigned TOTAL_W   = TOTAL_W_DEF,
  parameter int unsigned MAX_ITEMS = MAX_ITEMS_DEF
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                clear,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [PRICE_W-1:0]                  price,
  input  logic [NUM_W-1:0]                    num,
  input  logic                                last,
  output logic [PRICE_W-1:0]                  price_temp,
  output logic [NUM_W-1:0]                    num_temp,
  output logic [PRICE_W+NUM_W-1:0]            cur_unit_price,
  output logic [TOTAL_W-1:0]                  total,
  output logic [item_cnt_w(MAX_ITEMS)-1:0]    item_count,
  output logic                                overflow,
  output logic                                total_valid,
  input  logic                                out_ready
);

  localparam int unsigned PROD_W = PRICE_W + NUM_W;
  localparam int unsigned CNT_W  = item_cnt_w(MAX_ITEMS);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_last;
  logic              w_accept;
  logic              w_acc;
  logic              w_consume;
  logic              w_mul_busy;
  logic              w_mul_done;
  logic [PROD_W-1:0] w_product;
  sat_res_t          w_sat;
  logic              w_sat_ovf;

  seq_mult #(
    .PRICE_W (PRICE_W),
    .NUM_W   (NUM_W)
  ) u_mult (
    .clk     (clk),
    .rst     (rst),
    .clr     (clear),
    .start   (w_accept),
    .price   (price),
    .num     (num),
    .busy    (w_mul_busy),
    .done    (w_mul_done),
    .product (w_product)
  );

  // State register; clear behaves as a synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and per-state control strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_acc       = 1'b0;
    w_consume   = 1'b0;
    case (r_state)
      IDLE: begin
        if (in_valid && in_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = MUL;
        end
      end
      MUL: begin
        if (w_mul_done && !w_mul_busy) begin
          w_state_nxt = ACC;
        end
      end
      ACC: begin
        w_acc = 1'b1;
        if (r_last || (item_count == CNT_W'(MAX_ITEMS - 1))) begin
          w_state_nxt = DONE;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_consume   = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Upper sum bits are zero by construction; folding them in keeps every bit observed.
  always_comb begin
    w_sat     = sat_add(SAT_W'(total), SAT_W'(w_product), TOTAL_W);
    w_sat_ovf = w_sat.ovf | (|w_sat.sum[SAT_W-1:TOTAL_W]);
  end

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      in_ready       <= 1'b1;
      total_valid    <= 1'b0;
      price_temp     <= '0;
      num_temp       <= '0;
      r_last         <= 1'b0;
      cur_unit_price <= '0;
      total          <= '0;
      item_count     <= '0;
      overflow       <= 1'b0;
    end else begin
      in_ready    <= (w_state_nxt == IDLE);
      total_valid <= (w_state_nxt == DONE);
      if (w_accept) begin
        price_temp <= price;
        num_temp   <= num;
        r_last     <= last;
      end
      if (w_acc) begin
        cur_unit_price <= w_product;
        total          <= TOTAL_W'(w_sat.sum);
        overflow       <= overflow | w_sat_ovf;
        item_count     <= item_count + CNT_W'(1);
      end
      // Handing off the total starts a fresh order; item latches are kept.
      if (w_consume) begin
        total      <= '0;
        item_count <= '0;
        overflow   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_order_total.sv
// Directed bench for order_total: stimulus pushes expected order results to a
// queue, a monitor pops and compares on each rising total_valid.
module tb_order_total;

  localparam int unsigned PRICE_W   = 4;
  localparam int unsigned NUM_W     = 4;
  localparam int unsigned TOTAL_W   = 10;
  localparam int unsigned MAX_ITEMS = 8;
  localparam int unsigned CNT_W     = 4;

  logic                       clk = 1'b0;
  logic                       rst = 1'b0;
  logic                       clear = 1'b0;
  logic                       in_valid = 1'b0;
  logic                       in_ready;
  logic [PRICE_W-1:0]         price = '0;
  logic [NUM_W-1:0]           num = '0;
  logic                       last = 1'b0;
  logic [PRICE_W-1:0]         price_temp;
  logic [NUM_W-1:0]           num_temp;
  logic [PRICE_W+NUM_W-1:0]   cur_unit_price;
  logic [TOTAL_W-1:0]         total;
  logic [CNT_W-1:0]           item_count;
  logic                       overflow;
  logic                       total_valid;
  logic                       out_ready = 1'b0;

  always #5 clk = ~clk;

  order_total #(
    .PRICE_W   (PRICE_W),
    .NUM_W     (NUM_W),
    .TOTAL_W   (TOTAL_W),
    .MAX_ITEMS (MAX_ITEMS)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .clear          (clear),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .price          (price),
    .num            (num),
    .last           (last),
    .price_temp     (price_temp),
    .num_temp       (num_temp),
    .cur_unit_price (cur_unit_price),
    .total          (total),
    .item_count     (item_count),
    .overflow       (overflow),
    .total_valid    (total_valid),
    .out_ready      (out_ready)
  );

  typedef struct {
    int total;
    int cnt;
    int ovf;
    int cur;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_exp(input int t, input int c, input int o, input int u);
    exp_t e;
    e.total = t;
    e.cnt   = c;
    e.ovf   = o;
    e.cur   = u;
    sb_q.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge right after the accept edge.
  task automatic send(input int p, input int n, input bit l);
    int budget;
    budget = 0;
    while (!in_ready && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    chk("in_ready_before_send", 32'(in_ready), 1);
    in_valid = 1'b1;
    price    = PRICE_W'(p);
    num      = NUM_W'(n);
    last     = l;
    @(negedge clk);
    in_valid = 1'b0;
    price    = '0;
    num      = '0;
    last     = 1'b0;
  endtask

  task automatic check_line(input string name, input int cur, input int tot, input int cnt);
    chk({name, "_cur"},   32'(cur_unit_price), 32'(cur));
    chk({name, "_total"}, 32'(total),          32'(tot));
    chk({name, "_count"}, 32'(item_count),     32'(cnt));
  endtask

  task automatic check_zero(input string name);
    chk({name, "_in_ready"},    32'(in_ready),       1);
    chk({name, "_total_valid"}, 32'(total_valid),    0);
    chk({name, "_total"},       32'(total),          0);
    chk({name, "_count"},       32'(item_count),     0);
    chk({name, "_overflow"},    32'(overflow),       0);
    chk({name, "_price_temp"},  32'(price_temp),     0);
    chk({name, "_num_temp"},    32'(num_temp),       0);
    chk({name, "_cur"},         32'(cur_unit_price), 0);
  endtask

  task automatic consume(input string name);
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    chk({name, "_post_total"},    32'(total),       0);
    chk({name, "_post_count"},    32'(item_count),  0);
    chk({name, "_post_overflow"}, 32'(overflow),    0);
    chk({name, "_post_tv"},       32'(total_valid), 0);
    chk({name, "_post_in_ready"}, 32'(in_ready),    1);
  endtask

  // Scoreboard monitor: one expected order result per total_valid rise.
  initial begin
    logic prev_tv;
    exp_t e;
    prev_tv = 1'b0;
    forever begin
      @(negedge clk);
      if (total_valid && !prev_tv) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL sb_unexpected_done actual total=%0d required no completion", total);
        end else begin
          e = sb_q.pop_front();
          chk("sb_total",    32'(total),          32'(e.total));
          chk("sb_count",    32'(item_count),     32'(e.cnt));
          chk("sb_overflow", 32'(overflow),       32'(e.ovf));
          chk("sb_cur",      32'(cur_unit_price), 32'(e.cur));
        end
      end
      prev_tv = total_valid;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_tot;
    // Power-on reset
    step(2);
    rst = 1'b1;
    check_zero("rst_init");

    // Reset held two cycles in the middle of a multiply
    send(5, 5, 1'b0);
    step(2);
    rst = 1'b0;
    step(2);
    rst = 1'b1;
    check_zero("rst_mid");

    // Single item closing the order
    push_exp(20, 1, 0, 20);
    send(2, 10, 1'b1);
    step(NUM_W + 1);
    check_line("single", 20, 20, 1);
    chk("single_tv", 32'(total_valid), 1);
    consume("single");
    chk("single_keep_price", 32'(price_temp),     2);
    chk("single_keep_num",   32'(num_temp),       10);
    chk("single_keep_cur",   32'(cur_unit_price), 20);

    // Two items with an ignored in_valid pulse during MUL
    send(9, 2, 1'b0);
    in_valid = 1'b1;
    price    = 4'd7;
    num      = 4'd7;
    last     = 1'b1;
    step(1);
    in_valid = 1'b0;
    price    = '0;
    num      = '0;
    last     = 1'b0;
    step(NUM_W);
    check_line("two_a", 18, 18, 1);
    chk("two_a_num_temp", 32'(num_temp), 2);
    chk("two_a_in_ready", 32'(in_ready), 1);
    chk("two_a_tv",       32'(total_valid), 0);
    push_exp(33, 2, 0, 15);
    send(3, 5, 1'b1);
    step(NUM_W + 1);
    check_line("two_b", 15, 33, 2);
    chk("two_b_price_temp", 32'(price_temp), 3);
    consume("two");

    // Saturation on the fifth 15x15 item
    for (int i = 1; i <= 5; i++) begin
      if (i == 5) push_exp(1023, 5, 1, 225);
      send(15, 15, (i == 5));
      step(NUM_W + 1);
      exp_tot = (225 * i > 1023) ? 1023 : 225 * i;
      check_line($sformatf("ovf_%0d", i), 225, exp_tot, i);
      chk($sformatf("ovf_%0d_flag", i), 32'(overflow), (i == 5) ? 1 : 0);
    end
    step(3);
    chk("ovf_hold_flag",  32'(overflow),    1);
    chk("ovf_hold_total", 32'(total),       1023);
    chk("ovf_hold_tv",    32'(total_valid), 1);
    consume("ovf");

    // MAX_ITEMS forces the order closed without last
    for (int i = 1; i <= 8; i++) begin
      if (i == 8) push_exp(8, 8, 0, 1);
      send(1, 1, 1'b0);
      step(NUM_W + 1);
      check_line($sformatf("max_%0d", i), 1, i, i);
      chk($sformatf("max_%0d_tv", i), 32'(total_valid), (i == 8) ? 1 : 0);
    end
    consume("max");

    // Zero-price item still takes the full multiply latency
    send(0, 7, 1'b0);
    step(NUM_W);
    chk("zero_early_cur",   32'(cur_unit_price), 1);
    chk("zero_early_count", 32'(item_count),     0);
    step(1);
    check_line("zero", 0, 0, 1);
    push_exp(15, 2, 0, 15);
    send(5, 3, 1'b1);
    step(NUM_W + 1);
    check_line("zero_b", 15, 15, 2);
    consume("zero");

    // Abort via clear during the second multiply
    send(4, 4, 1'b0);
    step(NUM_W + 1);
    check_line("abort_a", 16, 16, 1);
    send(2, 2, 1'b0);
    step(2);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    check_zero("clear");

    // Reset while the order is waiting in DONE
    push_exp(9, 1, 0, 9);
    send(3, 3, 1'b1);
    step(NUM_W + 1);
    chk("rst_done_tv", 32'(total_valid), 1);
    rst = 1'b0;
    step(1);
    rst = 1'b1;
    check_zero("rst_done");

    step(2);
    chk("sb_empty", 32'(sb_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
